// File: rtl/mem_check_pkg.sv
// Shared FSM encoding and constants for the post-run memory result checker.
package mem_check_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RUN  = 3'd1,
        S_REQ  = 3'd2,
        S_CMP  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // Data recorded for an entry whose read was never acknowledged; sliced to DATA_W (<= 256).
    localparam int                    MAX_DATA_W   = 256;
    localparam logic [MAX_DATA_W-1:0] TIMEOUT_DATA = '1;

    localparam logic [6:0] FAIL_CNT_MAX = 7'd127;
    localparam int         MAX_ENTRIES  = 64;

endpackage

// File: rtl/mem_check_cmp.sv
// Masked equal / not-equal compare of one read value against its expected value.
// Purely combinational; no latency, no flow control.
module mem_check_cmp #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] i_data,
    input  logic [DATA_W-1:0] i_exp,
    input  logic [DATA_W-1:0] i_mask,
    input  logic              i_ne,
    output logic              o_ok
);

    logic w_eq;

    assign w_eq = ((i_data & i_mask) == (i_exp & i_mask));
    assign o_ok = i_ne ? !w_eq : w_eq;

endmodule

// File: rtl/mem_result_checker.sv
// Waits for program halt, then reads back N_CHECKS memory words and compares them to expected values.
// Halt-to-done is 1 + 3*N_CHECKS cycles with a one-cycle ack; MEM_CHECK_MASK_EN adds a per-entry compare mask.
module mem_result_checker
    import mem_check_pkg::*;
#(
    parameter int N_CHECKS   = 19,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RUN_CYCLES = 4125,
    parameter int ACK_TO     = 15
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic                         halt,
    input  logic [N_CHECKS*ADDR_W-1:0]   exp_addr,
    input  logic [N_CHECKS*DATA_W-1:0]   exp_data,
    input  logic [N_CHECKS-1:0]          exp_ne,
`ifdef MEM_CHECK_MASK_EN
    input  logic [N_CHECKS*DATA_W-1:0]   exp_mask,
`endif
    output logic                         rd_req,
    output logic [ADDR_W-1:0]            rd_addr,
    input  logic                         rd_ack,
    input  logic [DATA_W-1:0]            rd_data,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic [6:0]                   fail_cnt,
    output logic [5:0]                   first_fail_idx,
    output logic [DATA_W-1:0]            first_fail_data,
    output logic                         run_timeout
);

    state_t              r_state;
    logic [31:0]         r_cnt;
    logic [5:0]          r_idx;
    logic                r_rd_req;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_ack_to;
    logic                r_done;
    logic                r_pass;
    logic                r_timeout;
    logic [6:0]          r_fail_cnt;
    logic [5:0]          r_ff_idx;
    logic [DATA_W-1:0]   r_ff_data;

    // Tables padded to 64 entries so the 6-bit index selects without width games.
    logic [ADDR_W-1:0]   w_addr_tbl [MAX_ENTRIES];
    logic [DATA_W-1:0]   w_data_tbl [MAX_ENTRIES];
    logic                w_ne_tbl   [MAX_ENTRIES];
`ifdef MEM_CHECK_MASK_EN
    logic [DATA_W-1:0]   w_mask_tbl [MAX_ENTRIES];
`endif
    logic [DATA_W-1:0]   w_mask;
    logic                w_ok;
    logic                w_fail;
    logic [6:0]          w_fail_cnt_nx;

    for (genvar i = 0; i < MAX_ENTRIES; i++) begin : g_tbl
        if (i < N_CHECKS) begin : g_used
            assign w_addr_tbl[i] = exp_addr[i*ADDR_W +: ADDR_W];
            assign w_data_tbl[i] = exp_data[i*DATA_W +: DATA_W];
            assign w_ne_tbl[i]   = exp_ne[i];
`ifdef MEM_CHECK_MASK_EN
            assign w_mask_tbl[i] = exp_mask[i*DATA_W +: DATA_W];
`endif
        end else begin : g_pad
            assign w_addr_tbl[i] = '0;
            assign w_data_tbl[i] = '0;
            assign w_ne_tbl[i]   = 1'b0;
`ifdef MEM_CHECK_MASK_EN
            assign w_mask_tbl[i] = '0;
`endif
        end
    end

`ifdef MEM_CHECK_MASK_EN
    assign w_mask = w_mask_tbl[r_idx];
`else
    assign w_mask = '1;
`endif

    mem_check_cmp #(.DATA_W(DATA_W)) u_cmp (
        .i_data (r_rdata),
        .i_exp  (w_data_tbl[r_idx]),
        .i_mask (w_mask),
        .i_ne   (w_ne_tbl[r_idx]),
        .o_ok   (w_ok)
    );

    // An unacknowledged read fails regardless of what the all-ones data compares as.
    assign w_fail        = r_ack_to | !w_ok;
    assign w_fail_cnt_nx = (w_fail && r_fail_cnt != FAIL_CNT_MAX) ? r_fail_cnt + 7'd1 : r_fail_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_rd_req   <= 1'b0;
            r_rdata    <= '0;
            r_ack_to   <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_timeout  <= 1'b0;
            r_fail_cnt <= '0;
            r_ff_idx   <= '0;
            r_ff_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state    <= S_RUN;
                        r_cnt      <= '0;
                        r_idx      <= '0;
                        r_rdata    <= '0;
                        r_ack_to   <= 1'b0;
                        r_done     <= 1'b0;
                        r_pass     <= 1'b0;
                        r_timeout  <= 1'b0;
                        r_fail_cnt <= '0;
                        r_ff_idx   <= '0;
                        r_ff_data  <= '0;
                    end
                end
                S_RUN: begin
                    if (halt || r_cnt == 32'(RUN_CYCLES - 1)) begin
                        r_timeout <= !halt;
                        r_state   <= S_REQ;
                        r_rd_req  <= 1'b1;
                        r_cnt     <= '0;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                S_REQ: begin
                    if (rd_ack && r_rd_req) begin
                        r_rdata  <= rd_data;
                        r_ack_to <= 1'b0;
                        r_rd_req <= 1'b0;
                        r_state  <= S_CMP;
                    end else if (r_cnt == 32'(ACK_TO - 1)) begin
                        r_rdata  <= TIMEOUT_DATA[DATA_W-1:0];
                        r_ack_to <= 1'b1;
                        r_rd_req <= 1'b0;
                        r_state  <= S_CMP;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                S_CMP: begin
                    r_fail_cnt <= w_fail_cnt_nx;
                    if (w_fail && r_fail_cnt == 7'd0) begin
                        r_ff_idx  <= r_idx;
                        r_ff_data <= r_rdata;
                    end
                    if (r_idx != 6'(N_CHECKS - 1)) begin
                        r_idx    <= r_idx + 6'd1;
                        r_cnt    <= '0;
                        r_rd_req <= 1'b1;
                        r_state  <= S_REQ;
                    end else begin
                        r_done  <= 1'b1;
                        r_pass  <= (w_fail_cnt_nx == 7'd0) && !r_timeout;
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rd_req          = r_rd_req;
    assign rd_addr         = r_rd_req ? w_addr_tbl[r_idx] : '0;
    assign busy            = (r_state == S_RUN) || (r_state == S_REQ) || (r_state == S_CMP);
    assign done            = r_done;
    assign pass            = r_pass;
    assign fail_cnt        = r_fail_cnt;
    assign first_fail_idx  = r_ff_idx;
    assign first_fail_data = r_ff_data;
    assign run_timeout     = r_timeout;

endmodule
